// File: rtl/ccff_loader.sv
// Streams configuration bytes MSB-first into a ccff scan chain and returns
// the bits falling out of the chain tail as readback bytes.
module ccff_loader #(
    parameter int CHAIN_LEN = 12
) (
    input  logic       prog_clk,
    input  logic       prog_reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_BIT = 16'(CHAIN_LEN - 1);

    state_t      state_q,    state_d;
    logic [15:0] bit_cnt_q,  bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sreg_q,     sreg_d;
    logic [7:0]  rb_sreg_q,  rb_sreg_d;
    logic [7:0]  rb_data_q,  rb_data_d;
    logic        rb_valid_q, rb_valid_d;

    logic [7:0]  rb_next_byte;
    logic [7:0]  rb_aligned [8];
    logic        last_bit;
    logic        byte_end;

    assign rb_next_byte = {rb_sreg_q[6:0], ccff_tail};
    assign last_bit     = (bit_cnt_q == LAST_BIT);
    assign byte_end     = (byte_cnt_q == 3'd7);

    // rb_aligned[n-1] holds the current byte with n captured bits pushed to
    // the top and zeros below, so a short final byte comes out left-aligned.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_align
            assign rb_aligned[gi] = rb_next_byte << (7 - gi);
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        sreg_d        = sreg_q;
        rb_sreg_d     = rb_sreg_q;
        rb_data_d     = rb_data_q;
        rb_valid_d    = 1'b0;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d    = ST_FETCH;
                    bit_cnt_d  = 16'd0;
                    byte_cnt_d = 3'd0;
                    rb_sreg_d  = 8'd0;
                end
            end

            ST_FETCH: begin
                cfg_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cfg_valid) begin
                    sreg_d     = cfg_data;
                    byte_cnt_d = 3'd0;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = sreg_q[7];
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sreg_d     = {sreg_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 16'd1;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    rb_sreg_d  = rb_next_byte;
                    if (last_bit || byte_end) begin
                        rb_data_d  = rb_aligned[byte_cnt_q];
                        rb_valid_d = 1'b1;
                    end
                    // Final chain bit wins over a byte boundary; spare bits
                    // of the last byte are simply never shifted.
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end else if (byte_end) begin
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 16'd0;
            byte_cnt_q <= 3'd0;
            sreg_q     <= 8'd0;
            rb_sreg_q  <= 8'd0;
            rb_data_q  <= 8'd0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sreg_q     <= sreg_d;
            rb_sreg_q  <= rb_sreg_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ccff_loader.sv
// Randomised self-checking bench for ccff_loader: a bit-stream model of the
// chain load predicts head bits, accepted bytes, readback bytes and timing.
module tb_ccff_loader;

    localparam int CL = 12;
    localparam int NB = (CL + 7) / 8;

    logic       prog_clk     = 1'b0;
    logic       prog_reset_n = 1'b0;
    logic       start        = 1'b0;
    logic       abort        = 1'b0;
    logic [7:0] cfg_data     = 8'd0;
    logic       cfg_valid    = 1'b0;
    logic       ccff_tail    = 1'b0;
    logic       cfg_ready;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic       busy;
    logic       done;

    ccff_loader #(.CHAIN_LEN(CL)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 prog_clk = ~prog_clk;

    int vectors = 0;
    int errors  = 0;
    bit tail_tie = 1'b0;

    always @(posedge prog_clk) begin
        #1 ccff_tail = tail_tie ? 1'b1 : 1'($urandom_range(0, 1));
    end

    bit         head_q[$];
    bit         tail_q[$];
    logic [7:0] rb_q[$];
    logic [7:0] acc_q[$];
    int         fetch_cycles;
    int         glitch;
    int         overlap;

    always @(negedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            head_q.push_back(ccff_head);
            tail_q.push_back(ccff_tail);
        end else if (ccff_head !== 1'b0) begin
            glitch++;
        end
        if (cfg_ready === 1'b1) begin
            fetch_cycles++;
            if (cfg_valid) acc_q.push_back(cfg_data);
        end
        if (cfg_ready === 1'b1 && ccff_shift_en === 1'b1) overlap++;
        if (rb_valid === 1'b1) rb_q.push_back(rb_data);
    end

    logic [7:0] bytes_q[$];
    int         gaps_q[$];

    task automatic clear_mon();
        head_q.delete();
        tail_q.delete();
        rb_q.delete();
        acc_q.delete();
        fetch_cycles = 0;
        glitch       = 0;
        overlap      = 0;
    endtask

    // Model: the chain sees the byte stream MSB-first, truncated to CL bits.
    function automatic logic [CL-1:0] exp_head_vec();
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[CL-1-i] = bytes_q[i/8][7-(i%8)];
        return v;
    endfunction

    function automatic logic [CL-1:0] obs_head_vec();
        logic [CL-1:0] v = 'x;
        for (int i = 0; i < CL && i < head_q.size(); i++) v[CL-1-i] = head_q[i];
        return v;
    endfunction

    // Model: tail bits regrouped MSB-first into bytes, zero-filled at the end.
    function automatic logic [8*NB-1:0] exp_rb_vec();
        logic [8*NB-1:0] v = '0;
        for (int i = 0; i < CL; i++) v[8*NB-1-i] = (i < tail_q.size()) ? tail_q[i] : 1'bx;
        return v;
    endfunction

    function automatic logic [8*NB-1:0] obs_rb_vec();
        logic [8*NB-1:0] v = 'x;
        for (int k = 0; k < NB && k < rb_q.size(); k++) v[8*NB-1-8*k -: 8] = rb_q[k];
        return v;
    endfunction

    function automatic logic [8*NB-1:0] exp_acc_vec();
        logic [8*NB-1:0] v = '0;
        for (int k = 0; k < NB; k++) v[8*NB-1-8*k -: 8] = bytes_q[k];
        return v;
    endfunction

    function automatic logic [8*NB-1:0] obs_acc_vec();
        logic [8*NB-1:0] v = 'x;
        for (int k = 0; k < NB && k < acc_q.size(); k++) v[8*NB-1-8*k -: 8] = acc_q[k];
        return v;
    endfunction

    function automatic int gap_sum();
        int s = 0;
        foreach (gaps_q[k]) s += gaps_q[k];
        return s;
    endfunction

    // Drives one complete load; cycles counts from the start-sampling cycle
    // through the first cycle in which done is seen high.
    task automatic run_load(output int cycles, output bit timed_out);
        int idx = 0;
        int gap = (gaps_q.size() > 0) ? gaps_q[0] : 0;
        timed_out = 1'b1;
        cycles    = 0;
        @(posedge prog_clk); #1;
        start = 1'b1; cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        cycles = 1;
        for (int t = 0; t < 2000; t++) begin
            if (idx < bytes_q.size() && gap == 0) begin
                cfg_valid = 1'b1; cfg_data = bytes_q[idx];
            end else begin
                cfg_valid = 1'b0; cfg_data = 8'($urandom);
            end
            @(negedge prog_clk);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (cfg_ready === 1'b1) begin
                if (cfg_valid) begin
                    idx++;
                    gap = (idx < gaps_q.size()) ? gaps_q[idx] : 0;
                end else if (gap > 0) begin
                    gap--;
                end
            end
            @(posedge prog_clk); #1;
            cycles++;
        end
        cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        vectors++; if (cfg_ready !== 1'b0)     begin errors++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
        vectors++; if (ccff_head !== 1'b0)     begin errors++; $display("FAIL reset_head got=%b exp=0", ccff_head); end
        vectors++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en got=%b exp=0", ccff_shift_en); end
        vectors++; if (rb_valid !== 1'b0)      begin errors++; $display("FAIL reset_rb_valid got=%b exp=0", rb_valid); end
        vectors++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (rb_data !== 8'h00)      begin errors++; $display("FAIL reset_rb_data got=%h exp=00", rb_data); end
        @(posedge prog_clk); #1;
        prog_reset_n = 1'b1;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_directed();
        int cycles; bit to;
        bytes_q = '{8'hA5, 8'h3C};
        gaps_q  = '{0, 0};
        tail_tie = 1'b1;
        clear_mon();
        run_load(cycles, to);
        tail_tie = 1'b0;
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL dir_timeout got=%b exp=0", to); end
        vectors++; if (obs_head_vec() !== 12'b1010_0101_0011) begin errors++; $display("FAIL dir_head got=%b exp=101001010011", obs_head_vec()); end
        vectors++; if (head_q.size() !== CL) begin errors++; $display("FAIL dir_shift_cycles got=%0d exp=%0d", head_q.size(), CL); end
        vectors++; if (fetch_cycles !== 2) begin errors++; $display("FAIL dir_fetch_cycles got=%0d exp=2", fetch_cycles); end
        vectors++; if (cycles !== 15) begin errors++; $display("FAIL dir_done_latency got=%0d exp=15", cycles); end
        vectors++; if (obs_rb_vec() !== 16'hFFF0) begin errors++; $display("FAIL dir_rb got=%h exp=fff0", obs_rb_vec()); end
        vectors++; if (rb_q.size() !== 2) begin errors++; $display("FAIL dir_rb_count got=%0d exp=2", rb_q.size()); end
        vectors++; if (obs_acc_vec() !== 16'hA53C) begin errors++; $display("FAIL dir_accepted got=%h exp=a53c", obs_acc_vec()); end
        vectors++; if (glitch !== 0 || overlap !== 0) begin errors++; $display("FAIL dir_gating glitch=%0d overlap=%0d exp=0/0", glitch, overlap); end
        $display("test_directed: A5 3C latency=%0d head=%b rb=%h", cycles, obs_head_vec(), obs_rb_vec());
    endtask

    task automatic test_stall();
        int cycles; bit to;
        bytes_q = '{8'hA5, 8'h3C};
        gaps_q  = '{0, 5};
        clear_mon();
        run_load(cycles, to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout got=%b exp=0", to); end
        vectors++; if (obs_head_vec() !== 12'b1010_0101_0011) begin errors++; $display("FAIL stall_head got=%b exp=101001010011", obs_head_vec()); end
        vectors++; if (head_q.size() !== CL) begin errors++; $display("FAIL stall_shift_cycles got=%0d exp=%0d", head_q.size(), CL); end
        vectors++; if (fetch_cycles !== 7) begin errors++; $display("FAIL stall_fetch_cycles got=%0d exp=7", fetch_cycles); end
        vectors++; if (cycles !== 20) begin errors++; $display("FAIL stall_done_latency got=%0d exp=20", cycles); end
        vectors++; if (obs_rb_vec() !== exp_rb_vec()) begin errors++; $display("FAIL stall_rb got=%h exp=%h", obs_rb_vec(), exp_rb_vec()); end
        $display("test_stall: 5-cycle stall latency=%0d fetch=%0d", cycles, fetch_cycles);
    endtask

    task automatic test_random();
        int cycles; bit to;
        for (int n = 0; n < 6; n++) begin
            bytes_q.delete();
            gaps_q.delete();
            for (int k = 0; k < NB; k++) begin
                bytes_q.push_back(8'($urandom));
                gaps_q.push_back(int'($urandom_range(0, 3)));
            end
            clear_mon();
            run_load(cycles, to);
            vectors++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got=%b exp=0", n, to); end
            vectors++; if (obs_head_vec() !== exp_head_vec()) begin errors++; $display("FAIL rnd%0d_head got=%b exp=%b", n, obs_head_vec(), exp_head_vec()); end
            vectors++; if (head_q.size() !== CL) begin errors++; $display("FAIL rnd%0d_shift_cycles got=%0d exp=%0d", n, head_q.size(), CL); end
            vectors++; if (obs_acc_vec() !== exp_acc_vec() || acc_q.size() !== NB) begin errors++; $display("FAIL rnd%0d_accepted got=%h/%0d exp=%h/%0d", n, obs_acc_vec(), acc_q.size(), exp_acc_vec(), NB); end
            vectors++; if (obs_rb_vec() !== exp_rb_vec() || rb_q.size() !== NB) begin errors++; $display("FAIL rnd%0d_rb got=%h/%0d exp=%h/%0d", n, obs_rb_vec(), rb_q.size(), exp_rb_vec(), NB); end
            vectors++; if (fetch_cycles !== NB + gap_sum()) begin errors++; $display("FAIL rnd%0d_fetch_cycles got=%0d exp=%0d", n, fetch_cycles, NB + gap_sum()); end
            vectors++; if (cycles !== 1 + CL + NB + gap_sum()) begin errors++; $display("FAIL rnd%0d_done_latency got=%0d exp=%0d", n, cycles, 1 + CL + NB + gap_sum()); end
            vectors++; if (glitch !== 0 || overlap !== 0) begin errors++; $display("FAIL rnd%0d_gating glitch=%0d overlap=%0d exp=0/0", n, glitch, overlap); end
            $display("test_random[%0d]: bytes=%h gaps=%0d head=%b rb=%h", n, exp_acc_vec(), gap_sum(), obs_head_vec(), obs_rb_vec());
        end
    endtask

    task automatic test_reset_mid_shift();
        int cycles; bit to; bit got = 1'b0;
        clear_mon();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
        for (int t = 0; t < 20; t++) begin
            @(negedge prog_clk);
            if (cfg_ready === 1'b1) begin got = 1'b1; break; end
        end
        vectors++; if (got !== 1'b1) begin errors++; $display("FAIL rst_mid_fetch got=%b exp=1", got); end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
        repeat (4) begin @(posedge prog_clk); #1; end
        prog_reset_n = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        vectors++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL rst_mid_shift_en got=%b exp=0", ccff_shift_en); end
        vectors++; if ({cfg_ready, ccff_head, busy, done, rb_valid} !== 5'b0) begin errors++; $display("FAIL rst_mid_outputs got=%b exp=00000", {cfg_ready, ccff_head, busy, done, rb_valid}); end
        vectors++; if (rb_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rb_data got=%h exp=00", rb_data); end
        vectors++; if (head_q.size() !== 5 || rb_q.size() !== 0) begin errors++; $display("FAIL rst_mid_progress shifts=%0d rb=%0d exp=5/0", head_q.size(), rb_q.size()); end
        @(posedge prog_clk); #1;
        prog_reset_n = 1'b1;
        bytes_q = '{8'hA5, 8'h3C};
        gaps_q  = '{0, 0};
        clear_mon();
        run_load(cycles, to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL rst_reload_timeout got=%b exp=0", to); end
        vectors++; if (obs_head_vec() !== exp_head_vec() || head_q.size() !== CL) begin errors++; $display("FAIL rst_reload_head got=%b/%0d exp=%b/%0d", obs_head_vec(), head_q.size(), exp_head_vec(), CL); end
        vectors++; if (cycles !== 15) begin errors++; $display("FAIL rst_reload_latency got=%0d exp=15", cycles); end
        $display("test_reset_mid_shift: reload head=%b latency=%0d", obs_head_vec(), cycles);
    endtask

    task automatic test_start_abort();
        bit got = 1'b0;
        logic [7:0] h8;
        clear_mon();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A;
        for (int t = 0; t < 20; t++) begin
            @(negedge prog_clk);
            if (cfg_ready === 1'b1) begin got = 1'b1; break; end
        end
        vectors++; if (got !== 1'b1) begin errors++; $display("FAIL abort_fetch got=%b exp=1", got); end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
        repeat (2) begin @(posedge prog_clk); #1; end
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk);
        vectors++; if (ccff_shift_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL busy_start_ignored shift_en=%b busy=%b exp=1/1", ccff_shift_en, busy); end
        repeat (4) begin @(posedge prog_clk); #1; end
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0; cfg_valid = 1'b1;
        @(negedge prog_clk);
        vectors++; if ({busy, done, ccff_shift_en, cfg_ready} !== 4'b0) begin errors++; $display("FAIL abort_idle busy/done/shift/ready got=%b exp=0000", {busy, done, ccff_shift_en, cfg_ready}); end
        repeat (5) @(posedge prog_clk);
        #1 cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) h8[7-i] = (i < head_q.size()) ? head_q[i] : 1'bx;
        vectors++; if (h8 !== 8'h5A || head_q.size() !== 8) begin errors++; $display("FAIL abort_head got=%h/%0d exp=5a/8", h8, head_q.size()); end
        vectors++; if (rb_q.size() !== 0) begin errors++; $display("FAIL abort_no_rb got=%0d exp=0", rb_q.size()); end
        vectors++; if (done !== 1'b0 || acc_q.size() !== 1) begin errors++; $display("FAIL abort_stays_idle done=%b accepted=%0d exp=0/1", done, acc_q.size()); end
        $display("test_start_abort: head=%h shifts=%0d rb=%0d", h8, head_q.size(), rb_q.size());
    endtask

    task automatic test_done_transitions();
        int cycles; bit to;
        bytes_q = '{8'h81, 8'hFF};
        gaps_q  = '{1, 0};
        clear_mon();
        run_load(cycles, to);
        vectors++; if (done !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL done_level got=%b exp=1", done); end
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk);
        vectors++; if ({done, busy, cfg_ready} !== 3'b011) begin errors++; $display("FAIL restart_from_done done/busy/ready got=%b exp=011", {done, busy, cfg_ready}); end
        @(posedge prog_clk); #1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        run_load(cycles, to);
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        vectors++; if ({done, busy, cfg_ready} !== 3'b000) begin errors++; $display("FAIL abort_priority done/busy/ready got=%b exp=000", {done, busy, cfg_ready}); end
        @(posedge prog_clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        vectors++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL abort_priority_idle done/busy got=%b exp=00", {done, busy}); end
        $display("test_done_transitions: restart, abort-in-fetch and start+abort checked");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid_shift();
        test_start_abort();
        test_done_transitions();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 12, meaning the number of configuration flip-flops in the downstream ccff chain; legal range 1..65535.
REQ-002 SHALL have port prog_clk, input, 1 bit: the single clock; every flop in the block is clocked on the rising edge.
REQ-003 SHALL have port prog_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begins a load when sampled high in IDLE or DONE.
REQ-005 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-006 SHALL have port cfg_data, input, 8 bits: configuration byte, MSB shifted first.
REQ-007 SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial data to the chain head.
REQ-010 SHALL have port ccff_shift_en, output, 1 bit: chain clock enable, driving an external clock gate on prog_clk.
REQ-011 SHALL have port ccff_tail, input, 1 bit: serial data from the chain tail.
REQ-012 SHALL have port rb_data, output, 8 bits: readback byte.
REQ-013 SHALL have port rb_valid, output, 1 bit: one-cycle strobe qualifying rb_data; there is no backpressure.
REQ-014 SHALL have port busy, output, 1 bit: high in FETCH or SHIFT.
REQ-015 SHALL have port done, output, 1 bit: level, high in DONE.

Function
REQ-016 SHALL implement states IDLE, FETCH, SHIFT, DONE, with a 16-bit total bit counter, a 3-bit in-byte counter, an 8-bit data shift register and an 8-bit readback shift register.
REQ-017 IDLE/DONE: when start=1, SHALL clear all counters and go to FETCH; done falls in the same transition.
REQ-018 FETCH: SHALL drive cfg_ready=1; on cfg_valid&cfg_ready, SHALL load cfg_data into the shift register, clear the in-byte counter and go to SHIFT; otherwise SHALL stay in FETCH.
REQ-019 SHIFT: SHALL drive ccff_shift_en=1 and ccff_head=sreg[7], and each cycle SHALL shift sreg left by 1 and increment both counters.
REQ-020 SHIFT exit: if this cycle shifts bit CHAIN_LEN-1, SHALL go to DONE, discarding unused bits of a partial last byte; else if the in-byte counter is 7, SHALL go to FETCH; else SHALL stay in SHIFT.
REQ-021 Handshake: cfg_ready SHALL be 0 outside FETCH; exactly ceil(CHAIN_LEN/8) bytes SHALL be accepted per load; each accepted byte costs a minimum of one FETCH cycle.
REQ-022 Enable gating: ccff_shift_en SHALL be high only in SHIFT, for exactly CHAIN_LEN cycles per completed load; ccff_head SHALL be 0 whenever ccff_shift_en=0.
REQ-023 Stall: a FETCH wait with cfg_valid=0 SHALL keep ccff_shift_en=0 and SHALL not advance any counter, so the chain holds its state.
REQ-024 Readback capture: on every SHIFT cycle, SHALL shift ccff_tail (its value before the edge) into the readback register LSB, MSB-first.
REQ-025 Readback output: after every 8th captured bit, and after the final bit, rb_data SHALL present the byte with rb_valid=1 on the following cycle only.
REQ-026 Partial readback byte: a partial final byte SHALL be left-aligned with zero fill in the low bits.
REQ-027 Busy start: start SHALL be ignored in FETCH and SHIFT.
REQ-028 Abort: abort=1 in FETCH or SHIFT SHALL go to IDLE the next cycle with done=0 and no further rb_valid.
REQ-029 Abort priority: if start and abort are both high in IDLE or DONE, abort SHALL win and the state SHALL go to or stay in IDLE.

Reset
REQ-030 While prog_reset_n=0 at a clock edge, the state SHALL become IDLE, all counters and registers 0, and cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done SHALL all be 0, and rb_data SHALL be 8'h00.
REQ-031 Reset asserted mid-SHIFT SHALL drop ccff_shift_en on the next edge and SHALL not emit rb_valid.

Verification
REQ-032 With CHAIN_LEN=12, start, then bytes 0xA5 and 0x3C offered back-to-back -> ccff_head is 1,0,1,0,0,1,0,1,0,0,1,1 across 12 shift_en cycles, there are 2 FETCH cycles, done rises 15 cycles after start is sampled, and the low nibble of 0x3C is never shifted.
REQ-033 With ccff_tail tied 1 during the REQ-032 load -> rb_valid pulses twice, with rb_data 0xFF then 0xF0.
REQ-034 cfg_valid held low for 5 cycles before the second byte -> ccff_shift_en stays low for those 5 cycles and the head sequence is unchanged.
REQ-035 prog_reset_n pulsed low during bit 4 of the first byte -> all outputs are 0 next cycle; a new start then performs a full 12-bit load.
REQ-036 start re-pulsed mid-SHIFT -> it is ignored; abort mid-SHIFT -> IDLE with done=0; start after DONE -> done falls and a new load begins.
